nec_operand_fetch: RTL and testbench

Parametrised operand extractor between the instruction prefetch queue and the decoder's opcode/ModRM stage. Once opcode decode knows the displacement and immediate sizes, it pulses `start`. The block then pulls up to `FETCH_BYTES` bytes per `ce_1` from the circular queue and assembles `disp` and `imm`, with optional sign extension. It owns the fetch `pc`, honours branch flushes, and holds results until the execute stage retires them.

---
 rtl/nec_operand_fetch_if.sv | 39 +++
 rtl/nec_operand_fetch.sv | 202 ++++++++++++++++++++
 tb/tb_nec_operand_fetch.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/nec_operand_fetch_if.sv
// Handshake/bus bundle between the prefetch queue, the decoder and the
// operand fetch block.
interface nec_operand_fetch_if #(
  parameter int IPQ_DEPTH = 8,
  parameter int PC_WIDTH  = 16
);
  localparam int LENW = $clog2(IPQ_DEPTH) + 1;

  logic                           ce_1;
  logic                           ce_2;
  logic                           set_pc;
  logic [PC_WIDTH-1:0]            new_pc;
  logic [IPQ_DEPTH-1:0][7:0]      ipq;
  logic [LENW-1:0]                ipq_len;
  logic                           start;
  logic [2:0]                     disp_size;
  logic [2:0]                     imm_size;
  logic                           disp_sext;
  logic                           imm_sext;
  logic                           retire;
  logic [PC_WIDTH-1:0]            pc;
  logic [PC_WIDTH-1:0]            end_pc;
  logic [15:0]                    disp;
  logic [31:0]                    imm;
  logic                           busy;
  logic                           done;

  modport master (
    output ce_1, ce_2, set_pc, new_pc, ipq, ipq_len, start,
           disp_size, imm_size, disp_sext, imm_sext, retire,
    input  pc, end_pc, disp, imm, busy, done
  );

  modport slave (
    input  ce_1, ce_2, set_pc, new_pc, ipq, ipq_len, start,
           disp_size, imm_size, disp_sext, imm_sext, retire,
    output pc, end_pc, disp, imm, busy, done
  );
endinterface

// File: rtl/nec_operand_fetch.sv
// Operand extractor: pulls displacement/immediate bytes from the circular
// prefetch queue, owns the fetch pc and holds results until retired.
module nec_operand_fetch #(
  parameter int IPQ_DEPTH   = 8,
  parameter int FETCH_BYTES = 2,
  parameter int PC_WIDTH    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  nec_operand_fetch_if.slave bus
);
  localparam int IDXW = $clog2(IPQ_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_end_pc;
  logic [15:0]         r_disp;
  logic [31:0]         r_imm;
  logic                r_busy;
  logic                r_done;
  logic [1:0]          r_disp_size;
  logic [2:0]          r_imm_size;
  logic [1:0]          r_disp_read;
  logic [2:0]          r_imm_read;
  logic                r_disp_sext;
  logic                r_imm_sext;

  logic [1:0]          w_disp_size_in;
  logic [2:0]          w_imm_size_in;
  logic                w_zero_op;
  logic                w_flush;
  logic                w_begin;
  logic [2:0]          w_disp_left;
  logic [2:0]          w_imm_left;
  logic [31:0]         w_rem;
  logic [31:0]         w_n_q;
  logic [31:0]         w_n;
  logic [31:0]         w_n_disp;
  logic [31:0]         w_off;
  logic [IDXW-1:0]     w_idx;
  logic [1:0][7:0]     w_disp_b;
  logic [3:0][7:0]     w_imm_b;
  logic [1:0]          w_disp_read_nx;
  logic [2:0]          w_imm_read_nx;
  logic                w_last;

  // Size legalisation and start/flush qualification.
  always_comb begin
    w_disp_size_in = 2'd0;
    if (bus.disp_size <= 3'd2) begin
      w_disp_size_in = bus.disp_size[1:0];
    end else begin
      w_disp_size_in = 2'd0;
    end
    case (bus.imm_size)
      3'd1, 3'd2, 3'd4: w_imm_size_in = bus.imm_size;
      default:          w_imm_size_in = 3'd0;
    endcase
    w_zero_op = (w_disp_size_in == 2'd0) && (w_imm_size_in == 3'd0);
    w_flush   = (bus.ce_1 | bus.ce_2) & bus.set_pc;
    w_begin   = bus.ce_1 && bus.start &&
                ((r_state == S_IDLE) || ((r_state == S_DONE) && bus.retire));
  end

  // Per-cycle byte steering: displacement first, remainder spills into imm.
  always_comb begin
    w_disp_left = 3'(r_disp_size) - 3'(r_disp_read);
    w_imm_left  = r_imm_size - r_imm_read;
    w_rem       = 32'(w_disp_left) + 32'(w_imm_left);
    w_n_q       = (32'(bus.ipq_len) < 32'(FETCH_BYTES)) ? 32'(bus.ipq_len)
                                                        : 32'(FETCH_BYTES);
    w_n         = (w_rem < w_n_q) ? w_rem : w_n_q;
    w_n_disp    = (w_n < 32'(w_disp_left)) ? w_n : 32'(w_disp_left);
    w_disp_b    = r_disp;
    w_imm_b     = r_imm;
    w_off       = 32'd0;
    w_idx       = {IDXW{1'b0}};
    for (int k = 0; k < FETCH_BYTES; k++) begin
      if (32'(k) < w_n) begin
        w_idx = r_pc[IDXW-1:0] + IDXW'(k);
        if (32'(k) < w_n_disp) begin
          w_off = 32'(r_disp_read) + 32'(k);
          w_disp_b[w_off[0]] = bus.ipq[w_idx];
        end else begin
          w_off = 32'(r_imm_read) + 32'(k) - w_n_disp;
          w_imm_b[w_off[1:0]] = bus.ipq[w_idx];
        end
      end else begin
        w_idx = {IDXW{1'b0}};
      end
    end
    w_disp_read_nx = r_disp_read + 2'(w_n_disp);
    w_imm_read_nx  = r_imm_read + 3'(w_n - w_n_disp);
    // A 1-byte field is complete once its single byte has been read.
    if ((r_disp_size == 2'd1) && r_disp_sext && (w_disp_read_nx == 2'd1)) begin
      w_disp_b[1] = {8{w_disp_b[0][7]}};
    end else begin
      w_disp_b[1] = w_disp_b[1];
    end
    if ((r_imm_size == 3'd1) && r_imm_sext && (w_imm_read_nx == 3'd1)) begin
      w_imm_b[3:1] = {24{w_imm_b[0][7]}};
    end else begin
      w_imm_b[3:1] = w_imm_b[3:1];
    end
    w_last = (w_n == w_rem);
  end

  // Control FSM with registered pc and operand outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_pc        <= {PC_WIDTH{1'b0}};
      r_end_pc    <= {PC_WIDTH{1'b0}};
      r_disp      <= 16'd0;
      r_imm       <= 32'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_disp_size <= 2'd0;
      r_imm_size  <= 3'd0;
      r_disp_read <= 2'd0;
      r_imm_read  <= 3'd0;
      r_disp_sext <= 1'b0;
      r_imm_sext  <= 1'b0;
    end else if (w_flush) begin
      r_state  <= S_IDLE;
      r_pc     <= bus.new_pc;
      r_end_pc <= bus.new_pc;
      r_disp   <= 16'd0;
      r_imm    <= 32'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (bus.ce_1) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_begin) begin
            r_disp_size <= w_disp_size_in;
            r_imm_size  <= w_imm_size_in;
            r_disp_sext <= bus.disp_sext;
            r_imm_sext  <= bus.imm_sext;
            r_disp_read <= 2'd0;
            r_imm_read  <= 3'd0;
            r_disp      <= 16'd0;
            r_imm       <= 32'd0;
            if (w_zero_op) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FETCH;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end else if ((r_state == S_DONE) && bus.retire) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end else begin
            r_state <= r_state;
          end
        end
        S_FETCH: begin
          if (w_n != 32'd0) begin
            r_pc        <= r_pc + PC_WIDTH'(w_n);
            r_end_pc    <= r_end_pc + PC_WIDTH'(w_n);
            r_disp      <= w_disp_b;
            r_imm       <= w_imm_b;
            r_disp_read <= w_disp_read_nx;
            r_imm_read  <= w_imm_read_nx;
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FETCH;
            end
          end else begin
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end else begin
      r_state <= r_state;
    end
  end

  assign bus.pc     = r_pc;
  assign bus.end_pc = r_end_pc;
  assign bus.disp   = r_disp;
  assign bus.imm    = r_imm;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
endmodule

// File: tb/tb_nec_operand_fetch.sv
// Directed bench for nec_operand_fetch (IPQ_DEPTH=8, FETCH_BYTES=2, PC_WIDTH=16).
module tb_nec_operand_fetch;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  nec_operand_fetch_if #(.IPQ_DEPTH(8), .PC_WIDTH(16)) bus_if ();

  nec_operand_fetch #(.IPQ_DEPTH(8), .FETCH_BYTES(2), .PC_WIDTH(16)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic c1, input logic c2);
    @(negedge clk);
    bus_if.ce_1 = c1;
    bus_if.ce_2 = c2;
    @(posedge clk);
    #1;
    bus_if.ce_1 = 1'b0;
    bus_if.ce_2 = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    bus_if.ce_1 = 1'b0;  bus_if.ce_2 = 1'b0;
    bus_if.set_pc = 1'b0; bus_if.new_pc = 16'h0000;
    bus_if.ipq = '0;     bus_if.ipq_len = 4'd8;
    bus_if.start = 1'b0; bus_if.disp_size = 3'd0; bus_if.imm_size = 3'd0;
    bus_if.disp_sext = 1'b0; bus_if.imm_sext = 1'b0; bus_if.retire = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc",   32'(bus_if.pc), 32'h0);
    chk("rst_epc",  32'(bus_if.end_pc), 32'h0);
    chk("rst_disp", 32'(bus_if.disp), 32'h0);
    chk("rst_imm",  bus_if.imm, 32'h0);
    chk("rst_busy", 32'(bus_if.busy), 32'h0);
    chk("rst_done", 32'(bus_if.done), 32'h0);
    reset_n = 1'b1;

    // full queue, 4-byte fetch with index wrap 6,7,0,1
    bus_if.set_pc = 1'b1; bus_if.new_pc = 16'h0006; cyc(1'b1, 1'b0); bus_if.set_pc = 1'b0;
    chk("flush6_pc", 32'(bus_if.pc), 32'h6);
    bus_if.ipq[6] = 8'h11; bus_if.ipq[7] = 8'h22; bus_if.ipq[0] = 8'h33; bus_if.ipq[1] = 8'h44;
    bus_if.disp_size = 3'd2; bus_if.imm_size = 3'd2; bus_if.start = 1'b1;
    cyc(1'b1, 1'b0); bus_if.start = 1'b0;
    chk("full_busy0", 32'(bus_if.busy), 32'h1);
    chk("full_pc0",   32'(bus_if.pc), 32'h6);
    cyc(1'b1, 1'b0);
    chk("full_pc1",   32'(bus_if.pc), 32'h8);
    chk("full_disp1", 32'(bus_if.disp), 32'h2211);
    chk("full_done1", 32'(bus_if.done), 32'h0);
    cyc(1'b1, 1'b0);
    chk("full_disp", 32'(bus_if.disp), 32'h2211);
    chk("full_imm",  bus_if.imm, 32'h00004433);
    chk("full_pc",   32'(bus_if.pc), 32'h000A);
    chk("full_epc",  32'(bus_if.end_pc), 32'h000A);
    chk("full_done", 32'(bus_if.done), 32'h1);
    chk("full_busy", 32'(bus_if.busy), 32'h0);
    cyc(1'b1, 1'b0);
    chk("hold_done", 32'(bus_if.done), 32'h1);
    chk("hold_disp", 32'(bus_if.disp), 32'h2211);
    bus_if.retire = 1'b1; cyc(1'b1, 1'b0); bus_if.retire = 1'b0;
    chk("retire_done", 32'(bus_if.done), 32'h0);

    // starved queue, 4-byte immediate from pc 0x000A (index 2)
    bus_if.ipq[2] = 8'hA1; bus_if.ipq[3] = 8'hB2; bus_if.ipq[4] = 8'hC3; bus_if.ipq[5] = 8'hD4;
    bus_if.disp_size = 3'd0; bus_if.imm_size = 3'd4; bus_if.start = 1'b1;
    cyc(1'b1, 1'b0); bus_if.start = 1'b0;
    chk("stv_busy", 32'(bus_if.busy), 32'h1);
    bus_if.ipq_len = 4'd1; cyc(1'b1, 1'b0);
    chk("stv_pc1", 32'(bus_if.pc), 32'hB);
    bus_if.ipq_len = 4'd0; cyc(1'b1, 1'b0);
    chk("stv_pc2", 32'(bus_if.pc), 32'hB);
    cyc(1'b1, 1'b0);
    chk("stv_pc3",   32'(bus_if.pc), 32'hB);
    chk("stv_busy3", 32'(bus_if.busy), 32'h1);
    bus_if.ipq_len = 4'd3; cyc(1'b1, 1'b0);
    chk("stv_pc4",   32'(bus_if.pc), 32'hD);
    chk("stv_imm4",  bus_if.imm, 32'h00C3B2A1);
    chk("stv_done4", 32'(bus_if.done), 32'h0);
    bus_if.ipq_len = 4'd1; cyc(1'b1, 1'b0);
    chk("stv_pc5",  32'(bus_if.pc), 32'hE);
    chk("stv_imm",  bus_if.imm, 32'hD4C3B2A1);
    chk("stv_done", 32'(bus_if.done), 32'h1);
    bus_if.retire = 1'b1; cyc(1'b1, 1'b0); bus_if.retire = 1'b0;

    // sign extension, crossing from disp into imm within one cycle
    bus_if.ipq_len = 4'd8; bus_if.ipq[6] = 8'h80; bus_if.ipq[7] = 8'hFE;
    bus_if.disp_size = 3'd1; bus_if.imm_size = 3'd1;
    bus_if.disp_sext = 1'b1; bus_if.imm_sext = 1'b1; bus_if.start = 1'b1;
    cyc(1'b1, 1'b0); bus_if.start = 1'b0;
    cyc(1'b1, 1'b0);
    chk("sx_disp", 32'(bus_if.disp), 32'hFF80);
    chk("sx_imm",  bus_if.imm, 32'hFFFFFFFE);
    chk("sx_pc",   32'(bus_if.pc), 32'h10);
    chk("sx_done", 32'(bus_if.done), 32'h1);

    // back-to-back: retire + zero-size start in DONE
    bus_if.disp_sext = 1'b0; bus_if.imm_sext = 1'b0;
    bus_if.disp_size = 3'd0; bus_if.imm_size = 3'd0;
    bus_if.retire = 1'b1; bus_if.start = 1'b1;
    cyc(1'b1, 1'b0);
    chk("b2b_done", 32'(bus_if.done), 32'h1);
    chk("b2b_disp", 32'(bus_if.disp), 32'h0);
    chk("b2b_imm",  bus_if.imm, 32'h0);
    chk("b2b_busy", 32'(bus_if.busy), 32'h0);

    // flush mid-fetch on ce_2 with start also asserted
    bus_if.ipq[0] = 8'h5A; bus_if.disp_size = 3'd2;
    cyc(1'b1, 1'b0); bus_if.retire = 1'b0; bus_if.start = 1'b0;
    bus_if.ipq_len = 4'd1; cyc(1'b1, 1'b0);
    chk("fl_disp0", 32'(bus_if.disp), 32'h005A);
    chk("fl_pc0",   32'(bus_if.pc), 32'h11);
    chk("fl_busy0", 32'(bus_if.busy), 32'h1);
    bus_if.set_pc = 1'b1; bus_if.new_pc = 16'h1234; bus_if.start = 1'b1;
    bus_if.disp_size = 3'd0; bus_if.imm_size = 3'd0;
    cyc(1'b0, 1'b1); bus_if.set_pc = 1'b0;
    chk("fl_pc",   32'(bus_if.pc), 32'h1234);
    chk("fl_epc",  32'(bus_if.end_pc), 32'h1234);
    chk("fl_disp", 32'(bus_if.disp), 32'h0);
    chk("fl_imm",  bus_if.imm, 32'h0);
    chk("fl_busy", 32'(bus_if.busy), 32'h0);
    chk("fl_done", 32'(bus_if.done), 32'h0);
    cyc(1'b0, 1'b0);
    chk("noce_done", 32'(bus_if.done), 32'h0);

    // illegal sizes collapse to a zero-size op
    bus_if.disp_size = 3'd3; bus_if.imm_size = 3'd3;
    cyc(1'b1, 1'b0); bus_if.start = 1'b0;
    chk("ill_done", 32'(bus_if.done), 32'h1);
    chk("ill_busy", 32'(bus_if.busy), 32'h0);
    chk("ill_pc",   32'(bus_if.pc), 32'h1234);
    bus_if.retire = 1'b1; cyc(1'b1, 1'b0); bus_if.retire = 1'b0;

    // pc wrap 0xFFFF -> 0x0001 with a 2-byte immediate
    bus_if.set_pc = 1'b1; bus_if.new_pc = 16'hFFFF; cyc(1'b1, 1'b0); bus_if.set_pc = 1'b0;
    bus_if.ipq_len = 4'd8; bus_if.ipq[7] = 8'h34; bus_if.ipq[0] = 8'h12;
    bus_if.disp_size = 3'd0; bus_if.imm_size = 3'd2; bus_if.start = 1'b1;
    cyc(1'b1, 1'b0); bus_if.start = 1'b0;
    cyc(1'b1, 1'b0);
    chk("wrap_imm",  bus_if.imm, 32'h00001234);
    chk("wrap_pc",   32'(bus_if.pc), 32'h0001);
    chk("wrap_epc",  32'(bus_if.end_pc), 32'h0001);
    chk("wrap_done", 32'(bus_if.done), 32'h1);

    // asynchronous reset between edges during FETCH
    bus_if.ipq[1] = 8'h9C; bus_if.disp_size = 3'd2; bus_if.imm_size = 3'd2;
    bus_if.retire = 1'b1; bus_if.start = 1'b1;
    cyc(1'b1, 1'b0); bus_if.retire = 1'b0; bus_if.start = 1'b0;
    bus_if.ipq_len = 4'd1; cyc(1'b1, 1'b0);
    chk("ar_disp0", 32'(bus_if.disp), 32'h009C);
    chk("ar_busy0", 32'(bus_if.busy), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_pc",   32'(bus_if.pc), 32'h0);
    chk("ar_epc",  32'(bus_if.end_pc), 32'h0);
    chk("ar_disp", 32'(bus_if.disp), 32'h0);
    chk("ar_imm",  bus_if.imm, 32'h0);
    chk("ar_busy", 32'(bus_if.busy), 32'h0);
    chk("ar_done", 32'(bus_if.done), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_if.ipq_len = 4'd8; bus_if.ipq[0] = 8'h77;
    bus_if.disp_size = 3'd1; bus_if.imm_size = 3'd0; bus_if.start = 1'b1;
    cyc(1'b1, 1'b0); bus_if.start = 1'b0;
    chk("post_busy", 32'(bus_if.busy), 32'h1);
    cyc(1'b1, 1'b0);
    chk("post_disp", 32'(bus_if.disp), 32'h0077);
    chk("post_pc",   32'(bus_if.pc), 32'h1);
    chk("post_done", 32'(bus_if.done), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
